imm_scan_ctrl: RTL and testbench

Raster-scan sequencer for the image masking datapath. Accepts a pixel stream from the frame source, attaches the current (i, j) coordinate and the frame's latched mask offsets, and strobes the masking datapath once per pixel. It then writes each masked result into the VGA frame buffer at its raster address and signals completion once per frame. It sits between the camera/frame source and the masking stage, and is the only writer of the frame buffer during a masking pass.

---
 rtl/imm_scan_ctrl_pkg.sv | 27 ++
 rtl/imm_scan_ctrl_raster_cnt.sv | 44 ++++
 rtl/imm_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_imm_scan_ctrl.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_scan_ctrl_pkg.sv
// Shared types and constants for the raster-scan masking sequencer.
// Frame geometry defaults, bus widths, FSM encoding, address helper.
package imm_scan_ctrl_pkg;

  localparam int IMG_W_DEF = 320;
  localparam int IMG_H_DEF = 240;

  localparam int PIX_W  = 12;
  localparam int ADDR_W = 17;
  localparam int COL_W  = 9;
  localparam int ROW_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN
  } state_t;

  function automatic logic [ADDR_W-1:0] raster_addr(
    input logic [COL_W-1:0] i,
    input logic [ROW_W-1:0] j,
    input int               w
  );
    return ADDR_W'(j) * ADDR_W'(w) + ADDR_W'(i);
  endfunction

endpackage

// File: rtl/imm_scan_ctrl_raster_cnt.sv
// Column/row raster counters with wrap, last-pixel flag and
// frame-buffer address for the current coordinate.
module imm_raster_cnt
  import imm_scan_ctrl_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  output logic [COL_W-1:0]  i,
  output logic [ROW_W-1:0]  j,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [COL_W-1:0] I_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] J_MAX = ROW_W'(IMG_H - 1);

  logic i_end;
  logic j_end;

  assign i_end = (i == I_MAX);
  assign j_end = (j == J_MAX);
  assign last  = i_end && j_end;
  assign addr  = raster_addr(i, j, IMG_W);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      i <= '0;
      j <= '0;
    end else if (adv) begin
      if (i_end) begin
        i <= '0;
        j <= j_end ? '0 : j + 1'b1;
      end else begin
        i <= i + 1'b1;
      end
    end
  end

endmodule

// File: rtl/imm_scan_ctrl.sv
// Raster-scan sequencer: feeds source pixels to the masking datapath
// and writes the masked results into the frame buffer.
module imm_scan_ctrl
  import imm_scan_ctrl_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [COL_W-1:0]  i_offset_in,
  input  logic [ROW_W-1:0]  j_offset_in,
  input  logic              src_valid,
  input  logic [PIX_W-1:0]  src_pixel,
  output logic              src_ready,
  output logic [PIX_W-1:0]  imm_pixel,
  output logic [COL_W-1:0]  imm_i,
  output logic [ROW_W-1:0]  imm_j,
  output logic [COL_W-1:0]  imm_i_offset,
  output logic [ROW_W-1:0]  imm_j_offset,
  output logic              imm_tx,
  input  logic [PIX_W-1:0]  imm_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              busy,
  output logic              frame_done
);

  state_t state;

  logic              accept;
  logic              go;
  logic              cap;
  logic [ADDR_W-1:0] imm_addr;

  logic [COL_W-1:0]  cnt_i;
  logic [ROW_W-1:0]  cnt_j;
  logic [ADDR_W-1:0] cnt_addr;
  logic              cnt_last;

  assign accept = src_valid && src_ready && !abort;
  assign go     = (state == ST_IDLE) && start && !abort;

  imm_raster_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (go),
    .adv  (accept),
    .i    (cnt_i),
    .j    (cnt_j),
    .addr (cnt_addr),
    .last (cnt_last)
  );

  // cap marks the cycle in which imm_result is valid for capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      src_ready    <= 1'b0;
      imm_tx       <= 1'b0;
      cap          <= 1'b0;
      wr_en        <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      imm_pixel    <= '0;
      imm_i        <= '0;
      imm_j        <= '0;
      imm_i_offset <= '0;
      imm_j_offset <= '0;
      imm_addr     <= '0;
      wr_addr      <= '0;
      wr_data      <= '0;
    end else if (abort) begin
      state      <= ST_IDLE;
      src_ready  <= 1'b0;
      imm_tx     <= 1'b0;
      cap        <= 1'b0;
      wr_en      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      imm_tx     <= accept;
      cap        <= imm_tx;
      wr_en      <= cap;
      frame_done <= 1'b0;

      if (accept) begin
        imm_pixel <= src_pixel;
        imm_i     <= cnt_i;
        imm_j     <= cnt_j;
        imm_addr  <= cnt_addr;
      end

      if (cap) begin
        wr_addr <= imm_addr;
        wr_data <= imm_result;
      end

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            imm_i_offset <= i_offset_in;
            imm_j_offset <= j_offset_in;
            state        <= ST_SCAN;
            busy         <= 1'b1;
            src_ready    <= 1'b1;
          end
        end
        // ready drops for the strobe cycle so imm_tx returns low
        ST_SCAN: begin
          if (accept) begin
            src_ready <= 1'b0;
            if (cnt_last) begin
              state <= ST_DRAIN;
            end
          end else begin
            src_ready <= 1'b1;
          end
        end
        ST_DRAIN: begin
          src_ready <= 1'b0;
          if (cap) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_scan_ctrl.sv
// Randomised bench for imm_scan_ctrl on an 8x4 frame with a
// behavioural datapath and event logs compared against raster rules.
module tb_imm_scan_ctrl;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;
  localparam logic [11:0] MASK = 12'h5A5;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [8:0]  i_offset_in;
  logic [7:0]  j_offset_in;
  logic        src_valid;
  logic [11:0] src_pixel;
  logic        src_ready;
  logic [11:0] imm_pixel;
  logic [8:0]  imm_i;
  logic [7:0]  imm_j;
  logic [8:0]  imm_i_offset;
  logic [7:0]  imm_j_offset;
  logic        imm_tx;
  logic [11:0] imm_result;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;
  logic        busy;
  logic        frame_done;

  imm_scan_ctrl #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .i_offset_in  (i_offset_in),
    .j_offset_in  (j_offset_in),
    .src_valid    (src_valid),
    .src_pixel    (src_pixel),
    .src_ready    (src_ready),
    .imm_pixel    (imm_pixel),
    .imm_i        (imm_i),
    .imm_j        (imm_j),
    .imm_i_offset (imm_i_offset),
    .imm_j_offset (imm_j_offset),
    .imm_tx       (imm_tx),
    .imm_result   (imm_result),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // masking datapath stand-in: result valid the cycle after the strobe
  always @(posedge clk)
    imm_result <= imm_tx ? (imm_pixel ^ MASK) : 12'($urandom);

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;

  int acc_pix[$];
  int acc_cyc[$];
  int tx_pix[$];
  int tx_i[$];
  int tx_j[$];
  int tx_io[$];
  int tx_jo[$];
  int tx_cyc[$];
  int wr_a[$];
  int wr_d[$];
  int wr_dn[$];
  int wr_cyc[$];

  int done_cnt  = 0;
  int tx_consec = 0;
  int start_cyc = 0;
  bit prev_tx   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      prev_tx <= 1'b0;
    end else begin
      if (src_valid && src_ready && !abort) begin
        acc_pix.push_back(int'(src_pixel));
        acc_cyc.push_back(cyc);
      end
      if (imm_tx) begin
        tx_pix.push_back(int'(imm_pixel));
        tx_i.push_back(int'(imm_i));
        tx_j.push_back(int'(imm_j));
        tx_io.push_back(int'(imm_i_offset));
        tx_jo.push_back(int'(imm_j_offset));
        tx_cyc.push_back(cyc);
        if (prev_tx) tx_consec <= tx_consec + 1;
      end
      prev_tx <= imm_tx;
      if (wr_en) begin
        wr_a.push_back(int'(wr_addr));
        wr_d.push_back(int'(wr_data));
        wr_dn.push_back(int'(frame_done));
        wr_cyc.push_back(cyc);
      end
      if (frame_done) done_cnt <= done_cnt + 1;
      if (start && !busy && !abort) start_cyc <= cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_pix.delete(); acc_cyc.delete();
    tx_pix.delete();  tx_i.delete();  tx_j.delete();
    tx_io.delete();   tx_jo.delete(); tx_cyc.delete();
    wr_a.delete();    wr_d.delete();
    wr_dn.delete();   wr_cyc.delete();
  endtask

  task automatic start_frame(input int io, input int jo);
    start       = 1'b1;
    i_offset_in = 9'(io);
    j_offset_in = 8'(jo);
    src_valid   = 1'b0;
    step();
    start = 1'b0;
  endtask

  task automatic run_frame(input int pct, input bit idx,
                           input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      src_valid = (pct >= 100) || (int'($urandom_range(99)) < pct);
      src_pixel = idx ? 12'(acc_pix.size()) : 12'($urandom);
      step();
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
    src_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    chk_cnt++;
    if ({src_ready, imm_tx, wr_en, busy, frame_done} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000",
               {src_ready, imm_tx, wr_en, busy, frame_done});
    else pass_cnt++;
    chk_cnt++;
    if ({imm_pixel, imm_i, imm_j, imm_i_offset, imm_j_offset} !== '0)
      $display("FAIL reset_imm: got pix=%h i=%0d j=%0d io=%0d jo=%0d want 0",
               imm_pixel, imm_i, imm_j, imm_i_offset, imm_j_offset);
    else pass_cnt++;
    chk_cnt++;
    if ({wr_addr, wr_data} !== '0)
      $display("FAIL reset_wr: got addr=%0d data=%h want 0", wr_addr, wr_data);
    else pass_cnt++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_rate();
    bit ok;
    int d0, t0, ndone;
    clear_logs();
    d0 = done_cnt;
    t0 = tx_consec;
    start_frame(2, 1);
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL full_busy: got %b want 1", busy);
    else pass_cnt++;
    run_frame(100, 1'b1, 400, ok);
    src_valid = 1'b1;
    repeat (6) step();
    src_valid = 1'b0;
    chk_cnt++;
    if (!ok) $display("FAIL full_timeout: got no frame_done want done");
    else pass_cnt++;
    chk_cnt++;
    if (wr_a.size() != N)
      $display("FAIL full_wr_count: got %0d want %0d", wr_a.size(), N);
    else pass_cnt++;
    chk_cnt++;
    if (acc_cyc.size() == 0 || acc_cyc[0] != start_cyc + 1)
      $display("FAIL full_first_accept: got cyc %0d want %0d",
               acc_cyc.size() ? acc_cyc[0] : -1, start_cyc + 1);
    else pass_cnt++;
    ndone = 0;
    for (int k = 0; k < N && k < wr_a.size() && k < tx_i.size(); k++) begin
      chk_cnt++;
      if (wr_a[k] != k || wr_d[k] != int'(12'(k) ^ MASK))
        $display("FAIL full_wr[%0d]: got a=%0d d=%h want a=%0d d=%h",
                 k, wr_a[k], wr_d[k], k, 12'(k) ^ MASK);
      else pass_cnt++;
      chk_cnt++;
      if (tx_i[k] != k % W || tx_j[k] != k / W || tx_io[k] != 2 || tx_jo[k] != 1)
        $display("FAIL full_tx[%0d]: got i=%0d j=%0d io=%0d jo=%0d want %0d %0d 2 1",
                 k, tx_i[k], tx_j[k], tx_io[k], tx_jo[k], k % W, k / W);
      else pass_cnt++;
      chk_cnt++;
      if (tx_cyc[k] - acc_cyc[k] != 1 || wr_cyc[k] - acc_cyc[k] != 3)
        $display("FAIL full_lat[%0d]: got tx+%0d wr+%0d want tx+1 wr+3",
                 k, tx_cyc[k] - acc_cyc[k], wr_cyc[k] - acc_cyc[k]);
      else pass_cnt++;
      if (k > 0) begin
        chk_cnt++;
        if (acc_cyc[k] - acc_cyc[k-1] != 2)
          $display("FAIL full_rate[%0d]: got gap %0d want 2",
                   k, acc_cyc[k] - acc_cyc[k-1]);
        else pass_cnt++;
      end
      ndone += wr_dn[k];
    end
    chk_cnt++;
    if (ndone != 1 || wr_dn.size() != N || wr_dn[N-1] != 1)
      $display("FAIL full_done_pos: got %0d pulses on writes want 1 at addr %0d",
               ndone, N - 1);
    else pass_cnt++;
    chk_cnt++;
    if (done_cnt - d0 != 1)
      $display("FAIL full_done_cnt: got %0d want 1", done_cnt - d0);
    else pass_cnt++;
    chk_cnt++;
    if (tx_consec != t0)
      $display("FAIL full_tx_gap: got %0d back-to-back strobes want 0",
               tx_consec - t0);
    else pass_cnt++;
  endtask

  task automatic test_random_valid();
    bit ok;
    int d0, t0;
    clear_logs();
    d0 = done_cnt;
    t0 = tx_consec;
    start_frame(4, 3);
    run_frame(40, 1'b0, 3000, ok);
    repeat (6) step();
    chk_cnt++;
    if (!ok) $display("FAIL rand_timeout: got no frame_done want done");
    else pass_cnt++;
    chk_cnt++;
    if (wr_a.size() != N || acc_pix.size() != N)
      $display("FAIL rand_count: got wr=%0d acc=%0d want %0d",
               wr_a.size(), acc_pix.size(), N);
    else pass_cnt++;
    for (int k = 0; k < N && k < wr_a.size() && k < tx_pix.size(); k++) begin
      chk_cnt++;
      if (wr_a[k] != k || wr_d[k] != int'(12'(acc_pix[k]) ^ MASK))
        $display("FAIL rand_wr[%0d]: got a=%0d d=%h want a=%0d d=%h",
                 k, wr_a[k], wr_d[k], k, 12'(acc_pix[k]) ^ MASK);
      else pass_cnt++;
      chk_cnt++;
      if (tx_pix[k] != acc_pix[k] || tx_i[k] != k % W || tx_j[k] != k / W)
        $display("FAIL rand_tx[%0d]: got p=%h i=%0d j=%0d want p=%h i=%0d j=%0d",
                 k, tx_pix[k], tx_i[k], tx_j[k], acc_pix[k], k % W, k / W);
      else pass_cnt++;
      if (k > 0) begin
        chk_cnt++;
        if (acc_cyc[k] - acc_cyc[k-1] < 2)
          $display("FAIL rand_gap[%0d]: got %0d want >=2",
                   k, acc_cyc[k] - acc_cyc[k-1]);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (done_cnt - d0 != 1 || tx_consec != t0)
      $display("FAIL rand_done: got done=%0d consec=%0d want 1 0",
               done_cnt - d0, tx_consec - t0);
    else pass_cnt++;
  endtask

  task automatic test_offset_freeze();
    bit ok;
    int bad;
    clear_logs();
    start_frame(2, 1);
    i_offset_in = 9'd5;
    j_offset_in = 8'd7;
    run_frame(70, 1'b0, 2000, ok);
    repeat (4) step();
    bad = 0;
    for (int k = 0; k < tx_io.size(); k++)
      if (tx_io[k] != 2 || tx_jo[k] != 1) bad++;
    chk_cnt++;
    if (!ok || tx_io.size() != N || bad != 0)
      $display("FAIL offset_freeze: got ok=%0d tx=%0d bad=%0d want 1 %0d 0",
               ok, tx_io.size(), bad, N);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int d0, ntx, nwr, amax;
    clear_logs();
    d0 = done_cnt;
    start_frame(2, 1);
    for (int c = 0; c < 100; c++) begin
      if (acc_pix.size() >= 10) break;
      src_valid = 1'b1;
      src_pixel = 12'(acc_pix.size());
      step();
    end
    chk_cnt++;
    if (acc_pix.size() != 10)
      $display("FAIL abort_reach: got %0d accepts want 10", acc_pix.size());
    else pass_cnt++;
    abort = 1'b1;
    step();
    abort = 1'b0;
    ntx = tx_pix.size();
    nwr = wr_a.size();
    step();
    chk_cnt++;
    if (busy !== 1'b0 || src_ready !== 1'b0)
      $display("FAIL abort_busy: got busy=%b ready=%b want 0 0", busy, src_ready);
    else pass_cnt++;
    src_valid = 1'b1;
    repeat (30) step();
    src_valid = 1'b0;
    amax = -1;
    foreach (wr_a[k]) if (wr_a[k] > amax) amax = wr_a[k];
    chk_cnt++;
    if (tx_pix.size() != ntx || wr_a.size() != nwr || acc_pix.size() != 10)
      $display("FAIL abort_quiet: got tx=%0d wr=%0d acc=%0d want %0d %0d 10",
               tx_pix.size(), wr_a.size(), acc_pix.size(), ntx, nwr);
    else pass_cnt++;
    chk_cnt++;
    if (amax > 9 || done_cnt != d0)
      $display("FAIL abort_writes: got max addr=%0d done=%0d want <=9 0",
               amax, done_cnt - d0);
    else pass_cnt++;
  endtask

  task automatic test_start_busy();
    int d0, ntx, bad;
    bit ok;
    clear_logs();
    d0 = done_cnt;
    start_frame(3, 2);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      src_valid   = 1'b1;
      src_pixel   = 12'(acc_pix.size());
      start       = (c == 12);
      i_offset_in = 9'd7;
      step();
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
    start     = 1'b0;
    src_valid = 1'b0;
    repeat (4) step();
    bad = 0;
    foreach (wr_a[k]) if (wr_a[k] != k) bad++;
    foreach (tx_io[k]) if (tx_io[k] != 3) bad++;
    chk_cnt++;
    if (!ok || wr_a.size() != N || bad != 0 || done_cnt - d0 != 1)
      $display("FAIL start_busy: got ok=%0d wr=%0d bad=%0d done=%0d want 1 %0d 0 1",
               ok, wr_a.size(), bad, done_cnt - d0, N);
    else pass_cnt++;
    ntx   = tx_pix.size();
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk_cnt++;
    if (busy !== 1'b0 || src_ready !== 1'b0)
      $display("FAIL start_abort_idle: got busy=%b ready=%b want 0 0",
               busy, src_ready);
    else pass_cnt++;
    src_valid = 1'b1;
    repeat (6) step();
    src_valid = 1'b0;
    chk_cnt++;
    if (tx_pix.size() != ntx || busy !== 1'b0)
      $display("FAIL start_abort_quiet: got tx=%0d busy=%b want %0d 0",
               tx_pix.size(), busy, ntx);
    else pass_cnt++;
  endtask

  task automatic test_rst_mid();
    bit ok;
    int bad;
    clear_logs();
    start_frame(3, 2);
    for (int c = 0; c < 100; c++) begin
      if (acc_pix.size() >= 5) break;
      src_valid = 1'b1;
      src_pixel = 12'($urandom);
      step();
    end
    rst = 1'b1;
    step();
    chk_cnt++;
    if ({src_ready, imm_tx, wr_en, busy, frame_done} !== 5'b0)
      $display("FAIL rst_mid_ctrl: got %b want 00000",
               {src_ready, imm_tx, wr_en, busy, frame_done});
    else pass_cnt++;
    chk_cnt++;
    if ({imm_pixel, imm_i, imm_j, imm_i_offset, imm_j_offset, wr_addr, wr_data} !== '0)
      $display("FAIL rst_mid_data: got io=%0d addr=%0d data=%h want 0",
               imm_i_offset, wr_addr, wr_data);
    else pass_cnt++;
    rst       = 1'b0;
    src_valid = 1'b0;
    step();
    clear_logs();
    start_frame(6, 3);
    run_frame(100, 1'b1, 400, ok);
    repeat (4) step();
    bad = 0;
    foreach (wr_a[k]) if (wr_a[k] != k) bad++;
    foreach (tx_io[k]) if (tx_io[k] != 6 || tx_jo[k] != 3) bad++;
    chk_cnt++;
    if (!ok || wr_a.size() != N || bad != 0)
      $display("FAIL rst_restart: got ok=%0d wr=%0d bad=%0d want 1 %0d 0",
               ok, wr_a.size(), bad, N);
    else pass_cnt++;
    chk_cnt++;
    if (wr_a.size() == 0 || wr_a[0] != 0)
      $display("FAIL rst_first_addr: got %0d want 0",
               wr_a.size() ? wr_a[0] : -1);
    else pass_cnt++;
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    i_offset_in = '0;
    j_offset_in = '0;
    src_valid   = 1'b0;
    src_pixel   = '0;
    test_reset();
    test_full_rate();
    test_random_valid();
    test_offset_freeze();
    test_abort();
    test_start_busy();
    test_rst_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
